// File: rtl/banco_registradores.sv
// banco_registradores: general-purpose register file for the multicycle MIPS datapath.
//
// This block has 32 registers of DATA_W bits, two combinational read ports and one
// synchronous write port. $0 always reads as zero. $29, the stack pointer, resets to SP_RESET.
// Two operand latches, A and B, capture the read ports for the ALU cycle that follows.
//
// Ports:
//   clk        - single clock; all state updates on the rising edge
//   reset_n    - asynchronous, active-low reset
//   reg_write  - write enable for the register array
//   write_reg  - destination index (from the write-register mux)
//   write_data - data written to write_reg
//   read_reg1  - port 1 index (rs)
//   read_reg2  - port 2 index (rt)
//   load_a     - capture read_data1 into reg_a_out
//   load_b     - capture read_data2 into reg_b_out
//   read_data1 - combinational contents of read_reg1
//   read_data2 - combinational contents of read_reg2
//   reg_a_out  - registered operand A
//   reg_b_out  - registered operand B
module banco_registradores #(
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] SP_RESET = 32'd227
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reg_write,
  input  logic [4:0]        write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [4:0]        read_reg1,
  input  logic [4:0]        read_reg2,
  input  logic              load_a,
  input  logic              load_b,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] reg_a_out,
  output logic [DATA_W-1:0] reg_b_out
);

  localparam int unsigned NumRegs = 32;
  localparam logic [4:0]  SpIdx   = 5'd29;

  logic [DATA_W-1:0] rf_q [NumRegs];
  logic [NumRegs-1:0] wr_en;
  logic [DATA_W-1:0] reg_a_q, reg_a_d;
  logic [DATA_W-1:0] reg_b_q, reg_b_d;

  // One-hot write decode; entry 0 is never enabled, so $0 keeps its reset value of zero.
  always_comb begin
    wr_en = '0;
    if (reg_write && (write_reg != 5'd0)) begin
      wr_en[write_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        rf_q[i] <= (i == int'(SpIdx)) ? SP_RESET : '0;
      end
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        if (wr_en[i]) begin
          rf_q[i] <= write_data;
        end
      end
    end
  end

  // There is no write bypass. The read ports show the array contents before the edge
  // that commits a write.
  always_comb begin
    read_data1 = (read_reg1 == 5'd0) ? '0 : rf_q[read_reg1];
    read_data2 = (read_reg2 == 5'd0) ? '0 : rf_q[read_reg2];
  end

  always_comb begin
    reg_a_d = load_a ? read_data1 : reg_a_q;
    reg_b_d = load_b ? read_data2 : reg_b_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_a_q <= '0;
      reg_b_q <= '0;
    end else begin
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
    end
  end

  assign reg_a_out = reg_a_q;
  assign reg_b_out = reg_b_q;

endmodule

// File: tb/tb_banco_registradores.sv
// Directed testbench for banco_registradores. It uses hand-computed expected values.
module tb_banco_registradores;

  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              reset_n;
  logic              reg_write;
  logic [4:0]        write_reg;
  logic [DATA_W-1:0] write_data;
  logic [4:0]        read_reg1;
  logic [4:0]        read_reg2;
  logic              load_a;
  logic              load_b;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [DATA_W-1:0] reg_a_out;
  logic [DATA_W-1:0] reg_b_out;

  int n_vec;
  int n_bad;

  banco_registradores #(
    .DATA_W  (DATA_W),
    .SP_RESET(32'd227)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .reg_write (reg_write),
    .write_reg (write_reg),
    .write_data(write_data),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .load_a    (load_a),
    .load_b    (load_b),
    .read_data1(read_data1),
    .read_data2(read_data2),
    .reg_a_out (reg_a_out),
    .reg_b_out (reg_b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Move 1 time unit past the next rising edge, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec      = 0;
    n_bad      = 0;
    reset_n    = 1'b0;
    reg_write  = 1'b0;
    write_reg  = '0;
    write_data = '0;
    read_reg1  = '0;
    read_reg2  = '0;
    load_a     = 1'b0;
    load_b     = 1'b0;

    // Reset contents: $29 resets to 227 and every other register resets to 0.
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      #1;
      check($sformatf("rst_r%0d", i), read_data1, (i == 29) ? 32'd227 : 32'd0);
    end
    check("rst_a", reg_a_out, 32'd0);
    check("rst_b", reg_b_out, 32'd0);

    reset_n = 1'b1;
    tick();

    // Basic write, then read $8 on both ports.
    reg_write = 1'b1; write_reg = 5'd8; write_data = 32'hDEADBEEF;
    tick();
    reg_write = 1'b0; read_reg1 = 5'd8; read_reg2 = 5'd8;
    #1;
    check("wr8_rd1", read_data1, 32'hDEADBEEF);
    check("wr8_rd2", read_data2, 32'hDEADBEEF);
    load_a = 1'b1; load_b = 1'b1;
    tick();
    load_a = 1'b0; load_b = 1'b0;
    check("wr8_a", reg_a_out, 32'hDEADBEEF);
    check("wr8_b", reg_b_out, 32'hDEADBEEF);

    // A write to $0 is discarded and leaves the other registers unchanged.
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF;
    tick();
    reg_write = 1'b0; read_reg1 = 5'd0; read_reg2 = 5'd29;
    #1;
    check("r0_zero", read_data1, 32'd0);
    check("r0_sp", read_data2, 32'd227);
    read_reg1 = 5'd8;
    #1;
    check("r0_r8", read_data1, 32'hDEADBEEF);

    // Same-edge read and write: latch A must capture the old value of $31.
    reg_write = 1'b1; write_reg = 5'd31; write_data = 32'd5;
    tick();
    write_data = 32'd9; read_reg1 = 5'd31; load_a = 1'b1;
    #1;
    check("rw_pre", read_data1, 32'd5);
    tick();
    reg_write = 1'b0; load_a = 1'b0;
    check("rw_a_old", reg_a_out, 32'd5);
    check("rw_rd_new", read_data1, 32'd9);
    check("rw_b_hold", reg_b_out, 32'hDEADBEEF);
    load_a = 1'b1;
    tick();
    load_a = 1'b0;
    check("rw_a_new", reg_a_out, 32'd9);

    // With the write enable low, the write is ignored.
    reg_write = 1'b0; write_reg = 5'd29; write_data = 32'h1234;
    tick();
    read_reg1 = 5'd29;
    #1;
    check("we_gate", read_data1, 32'd227);

    // Asynchronous reset asserted mid-cycle.
    reg_write = 1'b1; write_reg = 5'd29; write_data = 32'd100;
    tick();
    reg_write = 1'b0; read_reg1 = 5'd29; load_a = 1'b1;
    tick();
    load_a = 1'b0;
    check("ar_a_pre", reg_a_out, 32'd100);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_sp", read_data1, 32'd227);
    check("ar_a", reg_a_out, 32'd0);
    check("ar_b", reg_b_out, 32'd0);
    // A write presented across an edge while reset is held is lost.
    reg_write = 1'b1; write_reg = 5'd8; write_data = 32'hCAFEF00D;
    tick();
    reg_write = 1'b0; read_reg1 = 5'd8; read_reg2 = 5'd31;
    #1;
    check("ar_r8", read_data1, 32'd0);
    check("ar_r31", read_data2, 32'd0);

    // After reset is released, the first edge can write.
    reset_n = 1'b1;
    reg_write = 1'b1; write_reg = 5'd5; write_data = 32'h0BADCAFE;
    tick();
    reg_write = 1'b0; read_reg2 = 5'd5;
    #1;
    check("post_rst_wr", read_data2, 32'h0BADCAFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
